// File: rtl/counter_mod_updown_pkg.sv
// Shared constants and parameter legality check for the modulo up/down counter.
`timescale 1ns/1ps
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic bit params_legal(input int width, input int modulo, input int sat_mode);
    return (width >= 2) && (width <= 16) &&
           (modulo >= 2) && (modulo <= (1 << width)) &&
           ((sat_mode == MODE_WRAP) || (sat_mode == MODE_SAT));
  endfunction

endpackage

// File: rtl/counter_mod_updown_step.sv
// Next-state logic for the modulo counter: load, increment/decrement, boundary detection.
`timescale 1ns/1ps
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             tc_next,
  output logic             ovf_event
);

  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULO - 1);
  localparam bit               SAT     = (SAT_MODE == MODE_SAT);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  // One spare bit: the carry past TOP and the borrow below zero are the boundary flags.
  assign cnt_ext  = {1'b0, count};
  assign load_ext = {1'b0, load_val};
  assign inc      = cnt_ext + 1'b1;
  assign dec      = cnt_ext - 1'b1;

  always_comb begin
    next_count = count;
    tc_next    = 1'b0;
    ovf_event  = 1'b0;
    if (load) begin
      if (load_ext > TOP_EXT) begin
        next_count = TOP;
        ovf_event  = 1'b1;
      end else begin
        next_count = load_val;
      end
    end else if (en) begin
      if (up) begin
        if (inc > TOP_EXT) begin
          next_count = SAT ? TOP : '0;
          tc_next    = 1'b1;
          ovf_event  = 1'b1;
        end else begin
          next_count = inc[WIDTH-1:0];
        end
      end else begin
        if (dec[WIDTH]) begin
          next_count = SAT ? '0 : TOP;
          tc_next    = 1'b1;
          ovf_event  = 1'b1;
        end else begin
          next_count = dec[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/counter_mod_updown.sv
// Pad-level modulo up/down counter: count, terminal-count pulse and sticky overflow registers.
`timescale 1ns/1ps
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             en_Pad,
  input  logic             up_Pad,
  input  logic             load_Pad,
  input  logic [WIDTH-1:0] load_val_Pad,
  output logic [WIDTH-1:0] count_Pad,
  output logic             tc_Pad,
  output logic             ovf_Pad
);

  generate
    if (!params_legal(WIDTH, MODULO, SAT_MODE)) begin : g_bad_params
      $error("counter_mod_updown: illegal WIDTH/MODULO/SAT_MODE combination");
    end
  endgenerate

  logic [WIDTH-1:0] next_count;
  logic             tc_next;
  logic             ovf_event;

  counter_step #(
    .WIDTH    (WIDTH),
    .MODULO   (MODULO),
    .SAT_MODE (SAT_MODE)
  ) u_step (
    .count      (count_Pad),
    .en         (en_Pad),
    .up         (up_Pad),
    .load       (load_Pad),
    .load_val   (load_val_Pad),
    .next_count (next_count),
    .tc_next    (tc_next),
    .ovf_event  (ovf_event)
  );

  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      count_Pad <= '0;
      tc_Pad    <= 1'b0;
      ovf_Pad   <= 1'b0;
    end else begin
      count_Pad <= next_count;
      tc_Pad    <= tc_next;
      ovf_Pad   <= ovf_Pad | ovf_event;
    end
  end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Bench: wrap and saturate instances (WIDTH=4, MODULO=10) driven in lockstep against a behavioural scoreboard.
`timescale 1ns/1ps
module tb_counter_mod_updown;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] cw, cs;
  logic         tw, ow, ts, os;

  int checks   = 0;
  int failures = 0;

  // Each entry packs {count_wrap, tc_wrap, ovf_wrap, count_sat, tc_sat, ovf_sat}.
  logic [11:0] sb[$];
  int mc[2];
  bit mt[2];
  bit mo[2];

  always #5 clk = ~clk;

  counter_mod_updown #(.WIDTH(W), .MODULO(M), .SAT_MODE(0)) dut_wrap (
    .GCLK_Pad(clk), .rst_Pad(rst), .en_Pad(en), .up_Pad(up), .load_Pad(load),
    .load_val_Pad(load_val), .count_Pad(cw), .tc_Pad(tw), .ovf_Pad(ow));

  counter_mod_updown #(.WIDTH(W), .MODULO(M), .SAT_MODE(1)) dut_sat (
    .GCLK_Pad(clk), .rst_Pad(rst), .en_Pad(en), .up_Pad(up), .load_Pad(load),
    .load_val_Pad(load_val), .count_Pad(cs), .tc_Pad(ts), .ovf_Pad(os));

  // Drive one edge worth of inputs, advance the model, push its prediction, then step past the edge.
  task automatic apply(input bit r, input bit e, input bit u, input bit l, input int lv);
    rst = r; en = e; up = u; load = l; load_val = W'(lv);
    for (int i = 0; i < 2; i++) begin
      mt[i] = 1'b0;
      if (r) begin
        mc[i] = 0; mo[i] = 1'b0;
      end else if (l) begin
        if (lv >= M) begin mc[i] = M - 1; mo[i] = 1'b1; end
        else mc[i] = lv;
      end else if (e && u) begin
        if (mc[i] == M - 1) begin mt[i] = 1'b1; mo[i] = 1'b1; mc[i] = (i == 1) ? M - 1 : 0; end
        else mc[i] = mc[i] + 1;
      end else if (e) begin
        if (mc[i] == 0) begin mt[i] = 1'b1; mo[i] = 1'b1; mc[i] = (i == 1) ? 0 : M - 1; end
        else mc[i] = mc[i] - 1;
      end
    end
    sb.push_back({W'(mc[0]), mt[0], mo[0], W'(mc[1]), mt[1], mo[1]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      apply(1, 1, 1, 1, 5);
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp || got !== 12'h0) begin
        failures++;
        $display("FAIL reset[%0d]: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [11:0] got, exp;
    for (int k = 0; k < 12; k++) begin
      apply(0, 1, 1, 0, 0);
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL wrap_up[%0d]: got %h expected %h", k, got, exp);
      end
    end
    checks++;
    if (cw !== 4'd2 || ow !== 1'b1 || cs !== 4'd9) begin
      failures++;
      $display("FAIL wrap_up_end: got cw=%0d ow=%b cs=%0d expected cw=2 ow=1 cs=9", cw, ow, cs);
    end
  endtask

  task automatic test_sat_up();
    logic [11:0] got, exp;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) apply(1, 0, 0, 0, 0);
      else if (k == 1) apply(0, 0, 0, 1, 8);
      else apply(0, 1, 1, 0, 0);
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL sat_up[%0d]: got %h expected %h", k, got, exp);
      end
    end
    checks++;
    if (cs !== 4'd9 || ts !== 1'b1 || os !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold: got cs=%0d ts=%b os=%b expected 9 1 1", cs, ts, os);
    end
  endtask

  task automatic test_wrap_down();
    logic [11:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) apply(1, 0, 0, 0, 0);
      else apply(0, 1, 0, 0, 0);
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL wrap_down[%0d]: got %h expected %h", k, got, exp);
      end
      if (k == 1) begin
        checks++;
        if (cw !== 4'd9 || tw !== 1'b1) begin
          failures++;
          $display("FAIL wrap_down_edge: got cw=%0d tw=%b expected 9 1", cw, tw);
        end
      end
    end
  endtask

  task automatic test_load();
    logic [11:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) apply(1, 0, 0, 0, 0);
      else if (k == 1) apply(0, 1, 1, 1, 12);
      else apply(0, 1, 1, 1, 3);
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL load[%0d]: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, exp;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) apply(1, 0, 0, 0, 0);
      else if (k < 8) apply(0, 1, 1, 0, 0);
      else apply(1, 1, 1, 1, 6);
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", k, got, exp);
      end
    end
    // Reset coinciding with a wrap boundary must still clear tc and ovf.
    apply(0, 0, 0, 1, 9);
    void'(sb.pop_front());
    apply(1, 1, 1, 0, 0);
    got = {cw, tw, ow, cs, ts, os};
    exp = sb.pop_front();
    checks++;
    if (got !== exp || got !== 12'h0) begin
      failures++;
      $display("FAIL reset_boundary: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_glitch();
    logic [11:0] got, exp;
    apply(0, 0, 0, 1, 4);
    void'(sb.pop_front());
    #3;
    en = 1'b1;
    #0.002;
    en = 1'b0;
    @(negedge clk);
    apply(0, 0, 1, 0, 0);
    got = {cw, tw, ow, cs, ts, os};
    exp = sb.pop_front();
    checks++;
    if (got !== exp || cw !== 4'd4) begin
      failures++;
      $display("FAIL glitch: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    for (int k = 0; k < 60; k++) begin
      apply(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 5) == 0), $urandom_range(0, 15));
      got = {cw, tw, ow, cs, ts, os};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random[%0d]: got %h expected %h", k, got, exp);
      end
    end
  endtask

  initial begin
    mc = '{0, 0};
    mt = '{0, 0};
    mo = '{0, 0};
    @(posedge clk);
    #1;
    test_reset();
    test_wrap_up();
    test_sat_up();
    test_wrap_down();
    test_load();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
